// File: rtl/vec_xform_pkg.sv
// rtl/vec_xform_pkg.sv - shared mode encodings and the vector transform function
//
// Contents:
//   MODE_PASS/MODE_INV/MODE_REV/MODE_GRAY : 2-bit transform selects
//   XFORM_MAX_W                           : widest vector xform() handles
//   xform(data, mode, width)              : applies the selected transform to
//                                           the low `width` bits of data and
//                                           returns it zero-extended
package vec_xform_pkg;

    localparam logic [1:0] MODE_PASS = 2'b00;
    localparam logic [1:0] MODE_INV  = 2'b01;
    localparam logic [1:0] MODE_REV  = 2'b10;
    localparam logic [1:0] MODE_GRAY = 2'b11;

    localparam int XFORM_MAX_W = 64;

    // Width is a run-time argument so one function serves every WIDTH
    // parameterisation; callers pass a constant, so it folds away in synthesis.
    function automatic logic [XFORM_MAX_W-1:0] xform(
        input logic [XFORM_MAX_W-1:0] data,
        input logic [1:0]             mode,
        input int                     width
    );
        logic [XFORM_MAX_W-1:0] mask;
        logic [XFORM_MAX_W-1:0] d;
        logic [XFORM_MAX_W-1:0] tmp;
        logic [XFORM_MAX_W-1:0] r;
        if (width >= XFORM_MAX_W) begin
            mask = '1;
        end else begin
            mask = (XFORM_MAX_W'(1) << width) - XFORM_MAX_W'(1);
        end
        d   = data & mask;
        tmp = d;
        r   = '0;
        case (mode)
            MODE_PASS: r = d;
            MODE_INV:  r = ~d & mask;
            MODE_REV: begin
                // Shift the LSB of the source into the LSB of the result each
                // step; after `width` steps source bit 0 sits at width-1.
                for (int i = 0; i < XFORM_MAX_W; i++) begin
                    if (i < width) begin
                        r   = {r[XFORM_MAX_W-2:0], tmp[0]};
                        tmp = tmp >> 1;
                    end
                end
            end
            default:   r = d ^ (d >> 1);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/vec_pipe_stage.sv
// rtl/vec_pipe_stage.sv - one elastic pipeline register with valid/data/mode
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   adv_next            : downstream stage (or consumer) can take a beat
//   up_valid/up_data/up_mode : beat offered by the upstream side
//   valid/data/mode     : registered beat held by this stage
//   adv                 : this stage loads on the next edge (empty or draining)
module vec_pipe_stage
    import vec_xform_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv_next,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic [1:0]       up_mode,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [1:0]       mode,
    output logic             adv
);

    // An empty stage always loads, which is what lets bubbles collapse while
    // the stages below it are stalled.
    assign adv = !valid || adv_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            mode  <= MODE_PASS;
        end else if (adv) begin
            valid <= up_valid;
            data  <= up_data;
            mode  <= up_mode;
        end
    end

endmodule

// File: rtl/vec_xform_pipe.sv
// rtl/vec_xform_pipe.sv - per-beat vector transform feeding a DEPTH-stage elastic pipeline
//
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   in_valid/in_ready             : source handshake
//   in_data[WIDTH], in_mode[2]    : input vector and transform select
//   out_valid/out_ready           : consumer handshake
//   out_data[WIDTH], out_mode[2]  : transformed vector and its mode
//   beat_cnt[CNT_W]               : wrapping count of output transfers
//   busy                          : any stage holds a valid beat
module vec_xform_pipe
    import vec_xform_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_mode,
    output logic [CNT_W-1:0] beat_cnt,
    output logic             busy
);

    // Index 0 is the transformed input; index k+1 is the output of stage k.
    logic [DEPTH:0]            vld;
    logic [DEPTH:0]            adv;
    logic [DEPTH:0][WIDTH-1:0] dat;
    logic [DEPTH:0][1:0]       mod;
    logic [XFORM_MAX_W-1:0]    xf_full;

    assign xf_full = xform(XFORM_MAX_W'(in_data), in_mode, WIDTH);

    assign vld[0]     = in_valid;
    assign dat[0]     = xf_full[WIDTH-1:0];
    assign mod[0]     = in_mode;
    assign adv[DEPTH] = out_ready;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        vec_pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .adv_next (adv[k+1]),
            .up_valid (vld[k]),
            .up_data  (dat[k]),
            .up_mode  (mod[k]),
            .valid    (vld[k+1]),
            .data     (dat[k+1]),
            .mode     (mod[k+1]),
            .adv      (adv[k])
        );
    end

    // Stage 0 only loads when adv[0] is high, so loading in_valid there is the
    // same as loading in_valid && in_ready.
    assign in_ready  = adv[0];
    assign out_valid = vld[DEPTH];
    assign out_data  = dat[DEPTH];
    assign out_mode  = mod[DEPTH];
    assign busy      = |vld[DEPTH:1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (out_valid && out_ready) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_vec_xform_pipe.sv
// tb/tb_vec_xform_pipe.sv - self-checking bench for vec_xform_pipe
module tb_vec_xform_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_data = '0;
    logic [1:0]  in_mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  out_data;
    logic [1:0]  out_mode;
    logic [15:0] beat_cnt;
    logic        busy;

    logic        p_in_valid = 1'b0;
    logic        p_in_ready;
    logic [7:0]  p_in_data = '0;
    logic [1:0]  p_in_mode = '0;
    logic        p_out_valid;
    logic        p_out_ready = 1'b1;
    logic [7:0]  p_out_data;
    logic [1:0]  p_out_mode;
    logic [2:0]  p_beat_cnt;
    logic        p_busy;

    int checks = 0;
    int failures = 0;

    logic [5:0] in_q[$];
    logic [5:0] out_q[$];

    always #5 clk = ~clk;

    vec_xform_pipe #(.WIDTH(4), .DEPTH(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode),
        .beat_cnt(beat_cnt), .busy(busy)
    );

    vec_xform_pipe #(.WIDTH(8), .DEPTH(4), .CNT_W(3)) dut_p (
        .clk(clk), .rst_n(rst_n),
        .in_valid(p_in_valid), .in_ready(p_in_ready), .in_data(p_in_data), .in_mode(p_in_mode),
        .out_valid(p_out_valid), .out_ready(p_out_ready), .out_data(p_out_data), .out_mode(p_out_mode),
        .beat_cnt(p_beat_cnt), .busy(p_busy)
    );

    // Inputs change 1 time unit after the rising edge, so the negedge snapshot
    // is exactly what the next rising edge will see.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready)   in_q.push_back({in_mode, in_data});
            if (out_valid && out_ready) out_q.push_back({out_mode, out_data});
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        p_in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        cyc();
        in_q.delete();
        out_q.delete();
    endtask

    // Reference transform from the textual rules, using integer arithmetic.
    function automatic int ref_x(input int d, input int m, input int w);
        int full;
        int r;
        full = (1 << w) - 1;
        d = d & full;
        r = 0;
        case (m)
            0: r = d;
            1: r = full - d;
            2: for (int i = 0; i < w; i++) r = r + (((d >> i) & 1) << (w - 1 - i));
            default: r = d ^ (d >> 1);
        endcase
        return r;
    endfunction

    typedef struct {
        logic [3:0] d;
        logic [1:0] m;
        logic [3:0] e;
    } vec_t;

    vec_t tbl[4];

    initial begin
        int n_acc;
        int n_cyc;
        bit accepted;
        logic [7:0] hold;

        tbl[0] = '{4'b1011, 2'b00, 4'b1011};
        tbl[1] = '{4'b0011, 2'b01, 4'b1100};
        tbl[2] = '{4'b1011, 2'b10, 4'b1101};
        tbl[3] = '{4'b1011, 2'b11, 4'b1110};

        // Reset state
        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_mode", out_mode, 0);
        check("rst_beat_cnt", beat_cnt, 0);
        check("rst_p_out_valid", p_out_valid, 0);
        #4 rst_n = 1'b1;
        cyc();
        check("rst_in_ready", in_ready, 1);

        // Table-driven basic sequence, out_ready held high
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = tbl[i].d;
            in_mode  = tbl[i].m;
            @(negedge clk);
            check($sformatf("tbl_lat_valid%0d", i), out_valid, (i >= 2) ? 1 : 0);
            if (i >= 2) check($sformatf("tbl_lat_data%0d", i), out_data, tbl[i-2].e);
            cyc();
        end
        in_valid = 1'b0;
        repeat (4) cyc();
        check("tbl_out_count", out_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < out_q.size()) begin
                check($sformatf("tbl_data%0d", i), out_q[i][3:0], tbl[i].e);
                check($sformatf("tbl_mode%0d", i), out_q[i][5:4], tbl[i].m);
            end
        end
        check("tbl_beat_cnt", beat_cnt, 4);

        // Backpressure
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 4'b1000; in_mode = 2'b00;
        cyc();
        in_data = 4'b0100;
        @(negedge clk);
        check("bp_ready_second", in_ready, 1);
        cyc();
        in_data = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("bp_in_ready%0d", i), in_ready, 0);
            check($sformatf("bp_hold_data%0d", i), out_data, 4'b1000);
            check($sformatf("bp_hold_valid%0d", i), out_valid, 1);
            cyc();
        end
        out_ready = 1'b1;
        accepted = 1'b0;
        n_cyc = 0;
        while (!accepted && n_cyc < 20) begin
            @(negedge clk);
            accepted = in_ready;
            cyc();
            n_cyc++;
        end
        check("bp_third_accepted", accepted, 1);
        in_valid = 1'b0;
        repeat (4) cyc();
        check("bp_out_count", out_q.size(), 3);
        if (out_q.size() == 3) begin
            check("bp_out0", out_q[0][3:0], 4'b1000);
            check("bp_out1", out_q[1][3:0], 4'b0100);
            check("bp_out2", out_q[2][3:0], 4'b0010);
        end

        // Bubble collapse
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 4'b0110; in_mode = 2'b00;
        cyc();
        in_valid = 1'b0;
        cyc();
        in_valid = 1'b1; in_data = 4'b1001; in_mode = 2'b01;
        @(negedge clk);
        check("bubble_in_ready", in_ready, 1);
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        check("bubble_busy", busy, 1);
        check("bubble_full", in_ready, 0);
        check("bubble_head", out_data, 4'b0110);
        check("bubble_accepts", in_q.size(), 2);

        // Asynchronous reset mid-operation
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 4'(i); in_mode = 2'b00;
            cyc();
        end
        in_valid = 1'b0;
        repeat (3) cyc();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 4'b1111;
        repeat (2) cyc();
        in_valid = 1'b0;
        @(negedge clk);
        check("mid_pre_cnt", beat_cnt, 5);
        check("mid_pre_full", in_ready, 0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_cnt", beat_cnt, 0);
        #1 rst_n = 1'b1;
        out_q.delete();
        in_q.delete();
        out_ready = 1'b1;
        cyc();
        check("mid_post_ready", in_ready, 1);
        repeat (4) cyc();
        check("mid_no_stale", out_q.size(), 0);
        check("mid_post_cnt", beat_cnt, 0);

        // Wide/deep build: latency, values, counter wrap
        p_out_ready = 1'b1;
        for (int t = 0; t < 2; t++) begin
            p_in_valid = 1'b1; p_in_data = 8'hB4; p_in_mode = (t == 0) ? 2'b10 : 2'b11;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                check($sformatf("p_lat%0d_%0d", t, i), p_out_valid, (i == 4) ? 1 : 0);
                if (i == 4) begin
                    hold = p_out_data;
                    check($sformatf("p_data%0d", t), hold, (t == 0) ? 8'h2D : 8'hEE);
                    check($sformatf("p_mode%0d", t), p_out_mode, p_in_mode);
                end
                cyc();
                p_in_valid = 1'b0;
            end
        end
        check("p_cnt2", p_beat_cnt, 2);
        for (int i = 0; i < 7; i++) begin
            p_in_valid = 1'b1; p_in_data = 8'(i); p_in_mode = 2'b00;
            cyc();
        end
        p_in_valid = 1'b0;
        repeat (6) cyc();
        check("p_cnt_wrap", p_beat_cnt, 1);
        check("p_idle", p_busy, 0);

        // Randomised traffic against the reference model
        do_reset();
        n_acc = 0;
        n_cyc = 0;
        while (n_acc < 1000 && n_cyc < 20000) begin
            in_valid  = ($urandom % 4) != 0;
            in_data   = 4'($urandom);
            in_mode   = 2'($urandom);
            out_ready = ($urandom % 3) != 0;
            @(negedge clk);
            if (in_valid && in_ready) n_acc++;
            cyc();
            n_cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (5) cyc();
        check("rand_accepted", n_acc, 1000);
        check("rand_out_count", out_q.size(), in_q.size());
        for (int i = 0; i < in_q.size(); i++) begin
            if (i < out_q.size()) begin
                check($sformatf("rand_beat%0d", i), out_q[i],
                      {in_q[i][5:4], 4'(ref_x(int'(in_q[i][3:0]), int'(in_q[i][5:4]), 4))});
            end
        end
        check("rand_beat_cnt", beat_cnt, 16'(out_q.size()));
        check("rand_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
